seq_alu: RTL and testbench

Parametrised, multi-cycle execute-stage ALU. Performs add, subtract, XOR and unsigned multiply on WIDTH-bit operands. Add, subtract and XOR complete in one cycle. Multiply uses an iterative shift-add datapath with a start/busy/done handshake. Results and flags are registered and held until the next operation completes.

---
 rtl/alu_pkg.sv | 16 +
 rtl/adder_subtractor.sv | 25 ++
 rtl/seq_alu.sv | 173 +++++++++++++++++
 tb/tb_seq_alu.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential execute-stage ALU.
package alu_pkg;

  // Operation encodings; bit 0 selects subtract on the adder path.
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_MUL = 2'b10;
  localparam logic [1:0] ALU_XOR = 2'b11;

  // Control states: idle (single-cycle ops handled here) and multiply in progress.
  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/adder_subtractor.sv
// WIDTH-bit adder/subtractor with carry/borrow and signed-overflow outputs.
module adder_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_sub,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry,
  output logic             o_ovf
);

  logic [WIDTH-1:0] w_b_eff;
  logic [WIDTH:0]   w_full;

  // Subtract is A + ~B + 1; the raw carry out is then the inverse of borrow.
  assign w_b_eff = i_sub ? ~i_b : i_b;
  assign w_full  = {1'b0, i_a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, i_sub};
  assign o_sum   = w_full[WIDTH-1:0];
  assign o_carry = i_sub ? ~w_full[WIDTH] : w_full[WIDTH];

  // Overflow: operands of equal effective sign produce a result of the other sign.
  assign o_ovf = (i_a[WIDTH-1] == w_b_eff[WIDTH-1]) && (o_sum[WIDTH-1] != i_a[WIDTH-1]);

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle execute-stage ALU: single-cycle ADD/SUB/XOR, iterative shift-add MUL.
//
// Handshake: start is sampled on a rising edge only while busy is low; the
// operands are captured on that same edge. A start seen while busy is high is
// dropped entirely. done is a one-cycle pulse marking the cycle in which
// out/out_hi/flags first show the new result; they then hold until the next
// completion or reset. Because the block is idle while done is high, a new
// start may be presented in the done cycle and is accepted.
module seq_alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       alu_op,
  input  logic [WIDTH-1:0] in_one,
  input  logic [WIDTH-1:0] in_two,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_hi,
  output logic             o,
  output logic             c,
  output logic             z,
  output logic             n
);

  import alu_pkg::*;

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t r_state;
  state_t w_state_next;

  logic [WIDTH-1:0]   r_mcand;
  logic [2*WIDTH-1:0] r_acc;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_out;
  logic [WIDTH-1:0]   r_out_hi;
  logic               r_o;
  logic               r_c;
  logic               r_z;
  logic               r_n;
  logic               r_done;

  logic [WIDTH-1:0]   w_add_sum;
  logic               w_add_c;
  logic               w_add_o;
  logic [WIDTH:0]     w_acc_sum;
  logic [2*WIDTH-1:0] w_acc_next;
  logic               w_load;
  logic               w_mul_start;
  logic [WIDTH-1:0]   w_res_lo;
  logic [WIDTH-1:0]   w_res_hi;
  logic               w_res_o;
  logic               w_res_c;
  logic               w_res_z;
  logic               w_res_n;

  adder_subtractor #(
    .WIDTH(WIDTH)
  ) u_addsub (
    .i_a    (in_one),
    .i_b    (in_two),
    .i_sub  (alu_op[0]),
    .o_sum  (w_add_sum),
    .o_carry(w_add_c),
    .o_ovf  (w_add_o)
  );

  // Shift-add step: upper half accumulates the multiplicand when the
  // multiplier LSB is set; the carry out shifts back in at the top.
  assign w_acc_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
                      (r_acc[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
  assign w_acc_next = {w_acc_sum, r_acc[WIDTH-1:1]};

  // Next-state and next-result selection.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_mul_start  = 1'b0;
    w_res_lo     = '0;
    w_res_hi     = '0;
    w_res_o      = 1'b0;
    w_res_c      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (alu_op == ALU_MUL) begin
            w_mul_start  = 1'b1;
            w_state_next = S_MUL;
          end else begin
            w_load = 1'b1;
            case (alu_op)
              ALU_XOR: w_res_lo = in_one ^ in_two;
              default: begin
                w_res_lo = w_add_sum;
                w_res_o  = w_add_o;
                w_res_c  = w_add_c;
              end
            endcase
          end
        end
      end
      S_MUL: begin
        if (r_cnt == LAST) begin
          w_load       = 1'b1;
          w_state_next = S_IDLE;
          w_res_lo     = w_acc_next[WIDTH-1:0];
          w_res_hi     = w_acc_next[2*WIDTH-1:WIDTH];
          w_res_c      = |w_acc_next[2*WIDTH-1:WIDTH];
          w_res_o      = |w_acc_next[2*WIDTH-1:WIDTH];
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Zero covers both product halves; sign comes from the top of the full result.
  assign w_res_z = ~|{w_res_hi, w_res_lo};
  assign w_res_n = (r_state == S_MUL) ? w_res_hi[WIDTH-1] : w_res_lo[WIDTH-1];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Multiply datapath, result/flag registers and done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcand  <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_out    <= '0;
      r_out_hi <= '0;
      r_o      <= 1'b0;
      r_c      <= 1'b0;
      r_z      <= 1'b0;
      r_n      <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_load;
      if (w_load) begin
        r_out    <= w_res_lo;
        r_out_hi <= w_res_hi;
        r_o      <= w_res_o;
        r_c      <= w_res_c;
        r_z      <= w_res_z;
        r_n      <= w_res_n;
      end
      if (w_mul_start) begin
        r_mcand <= in_one;
        r_acc   <= {{WIDTH{1'b0}}, in_two};
        r_cnt   <= '0;
      end else if (r_state == S_MUL) begin
        r_acc <= w_acc_next;
        r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CW'(1);
      end
    end
  end

  assign busy   = (r_state == S_MUL);
  assign done   = r_done;
  assign out    = r_out;
  assign out_hi = r_out_hi;
  assign o      = r_o;
  assign c      = r_c;
  assign z      = r_z;
  assign n      = r_n;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=8): table vectors, directed
// multi-cycle sequences and randomized ops against an arithmetic model.
module tb_seq_alu;

  import alu_pkg::*;

  localparam int W = 8;
  localparam longint MOD  = longint'(1) << W;
  localparam longint SMAX = (longint'(1) << (W - 1)) - 1;
  localparam longint SMIN = -(longint'(1) << (W - 1));

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         o;
    logic         c;
    logic         z;
    logic         n;
  } res_t;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    res_t         exp;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   alu_op;
  logic [W-1:0] in_one;
  logic [W-1:0] in_two;
  logic         busy;
  logic         done;
  logic [W-1:0] out;
  logic [W-1:0] out_hi;
  logic         o;
  logic         c;
  logic         z;
  logic         n;

  int   checks   = 0;
  int   failures = 0;
  res_t exp_q[$];
  res_t cur;
  res_t held;
  logic rst_at_edge = 1'b1;
  logic started     = 1'b0;

  seq_alu #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .alu_op(alu_op),
    .in_one(in_one),
    .in_two(in_two),
    .busy  (busy),
    .done  (done),
    .out   (out),
    .out_hi(out_hi),
    .o     (o),
    .c     (c),
    .z     (z),
    .n     (n)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  assign cur = {out_hi, out, o, c, z, n};

  // ---------------- reference model ----------------
  function automatic res_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint ua = longint'(a);
    longint ub = longint'(b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint full;
    longint sres;
    res_t   r;
    r = '0;
    case (op)
      ALU_ADD: begin
        full = ua + ub;
        r.lo = W'(full);
        r.c  = (full >= MOD);
        sres = sa + sb;
        r.o  = (sres > SMAX) || (sres < SMIN);
      end
      ALU_SUB: begin
        full = ua - ub;
        r.lo = W'(full + MOD);
        r.c  = (ua < ub);
        sres = sa - sb;
        r.o  = (sres > SMAX) || (sres < SMIN);
      end
      ALU_MUL: begin
        full = ua * ub;
        r.lo = W'(full);
        r.hi = W'(full >> W);
        r.c  = ((full >> W) != 0);
        r.o  = r.c;
      end
      default: r.lo = a ^ b;
    endcase
    r.z = (r.hi == 0) && (r.lo == 0);
    r.n = (op == ALU_MUL) ? r.hi[W-1] : r.lo[W-1];
    return r;
  endfunction

  function automatic res_t mk(input logic [W-1:0] hi, input logic [W-1:0] lo,
                              input logic fo, input logic fc, input logic fz, input logic fn);
    res_t r;
    r.hi = hi; r.lo = lo; r.o = fo; r.c = fc; r.z = fz; r.n = fn;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(posedge clk) rst_at_edge <= rst;

  always @(negedge clk) begin
    if (started) begin
      if (done) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done got=done with empty queue out_hi=%h out=%h at %0t", out_hi, out, $time);
        end else begin
          check("sb_result", 32'(cur), 32'(exp_q.pop_front()));
        end
      end else if (!rst_at_edge) begin
        check("hold_outputs", 32'(cur), 32'(held));
      end
    end
    held = cur;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op and wait for its done; lat counts edges after the start edge.
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output int bcnt);
    alu_op = op;
    in_one = a;
    in_two = b;
    start  = 1'b1;
    exp_q.push_back(model(op, a, b));
    tick();
    start = 1'b0;
    lat   = 0;
    bcnt  = 0;
    while (!done && lat < 20) begin
      if (busy) bcnt++;
      tick();
      lat++;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL timeout got=no done exp=done op=%0d at %0t", op, $time);
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin : main
    vec_t tbl[9];
    int   lat;
    int   bcnt;
    int   n_done;
    res_t cap;
    logic [1:0] rop;

    tbl[0] = '{ALU_ADD, 8'h7F, 8'h01, mk(8'h00, 8'h80, 1'b1, 1'b0, 1'b0, 1'b1)};
    tbl[1] = '{ALU_ADD, 8'hFF, 8'h01, mk(8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0)};
    tbl[2] = '{ALU_SUB, 8'h10, 8'h20, mk(8'h00, 8'hF0, 1'b0, 1'b1, 1'b0, 1'b1)};
    tbl[3] = '{ALU_SUB, 8'h80, 8'h01, mk(8'h00, 8'h7F, 1'b1, 1'b0, 1'b0, 1'b0)};
    tbl[4] = '{ALU_MUL, 8'hFF, 8'hFF, mk(8'hFE, 8'h01, 1'b1, 1'b1, 1'b0, 1'b1)};
    tbl[5] = '{ALU_MUL, 8'h00, 8'h5A, mk(8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0)};
    tbl[6] = '{ALU_XOR, 8'hA5, 8'hA5, mk(8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0)};
    tbl[7] = '{ALU_XOR, 8'h0F, 8'hF0, mk(8'h00, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1)};
    tbl[8] = '{ALU_MUL, 8'h10, 8'h03, mk(8'h00, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0)};

    // Reset
    rst = 1'b1; start = 1'b0; alu_op = ALU_ADD; in_one = '0; in_two = '0;
    repeat (2) tick();
    check("reset_state", 32'({busy, done, cur}), 32'(0));
    rst = 1'b0;
    started = 1'b1;

    // Table vectors, each followed by an idle cycle where done must drop
    for (int i = 0; i < 9; i++) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, lat, bcnt);
      check($sformatf("tbl%0d_result", i), 32'(cur), 32'(tbl[i].exp));
      check($sformatf("tbl%0d_latency", i), 32'(lat), (tbl[i].op == ALU_MUL) ? 32'(W) : 32'(0));
      check($sformatf("tbl%0d_busy_cycles", i), 32'(bcnt), (tbl[i].op == ALU_MUL) ? 32'(W) : 32'(0));
      check($sformatf("tbl%0d_busy_at_done", i), 32'(busy), 32'(0));
      tick();
      check($sformatf("tbl%0d_done_drop", i), 32'(done), 32'(0));
    end

    // Start during an active multiply is ignored
    alu_op = ALU_MUL; in_one = 8'h0D; in_two = 8'h0B; start = 1'b1;
    exp_q.push_back(model(ALU_MUL, 8'h0D, 8'h0B));
    tick();
    start = 1'b0;
    repeat (3) tick();
    alu_op = ALU_ADD; in_one = 8'h01; in_two = 8'h01; start = 1'b1;
    tick();
    start  = 1'b0;
    n_done = 0;
    cap    = '0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) begin
        n_done++;
        cap = cur;
      end
    end
    check("ignore_done_count", 32'(n_done), 32'(1));
    check("ignore_result", 32'(cap), 32'(mk(8'h00, 8'h8F, 1'b0, 1'b0, 1'b0, 1'b0)));

    // Reset four cycles into a multiply aborts it
    alu_op = ALU_MUL; in_one = 8'hFF; in_two = 8'hFF; start = 1'b1;
    exp_q.push_back(model(ALU_MUL, 8'hFF, 8'hFF));
    tick();
    start = 1'b0;
    repeat (4) tick();
    check("abort_busy_before", 32'(busy), 32'(1));
    rst = 1'b1;
    exp_q.delete();
    tick();
    rst = 1'b0;
    check("abort_state", 32'({busy, done, cur}), 32'(0));
    n_done = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done) n_done++;
    end
    check("abort_no_done", 32'(n_done), 32'(0));
    run_op(ALU_ADD, 8'h03, 8'h04, lat, bcnt);
    check("after_abort_add", 32'(cur), 32'(mk(8'h00, 8'h07, 1'b0, 1'b0, 1'b0, 1'b0)));

    // MUL followed by ADD presented in the done cycle
    run_op(ALU_MUL, 8'h12, 8'h34, lat, bcnt);
    check("b2b_mul", 32'(cur), 32'(mk(8'h03, 8'hA8, 1'b1, 1'b1, 1'b0, 1'b0)));
    run_op(ALU_ADD, 8'h20, 8'h22, lat, bcnt);
    check("b2b_add_latency", 32'(lat), 32'(0));
    check("b2b_add_result", 32'(cur), 32'(mk(8'h00, 8'h42, 1'b0, 1'b0, 1'b0, 1'b0)));

    // Consecutive single-cycle ops: done high every cycle
    for (int i = 0; i < 8; i++) begin
      rop = 2'($urandom_range(0, 2));
      if (rop == ALU_MUL) rop = ALU_XOR;
      run_op(rop, W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), lat, bcnt);
      check("consec_latency", 32'(lat), 32'(0));
    end

    // Randomized ops against the model
    for (int i = 0; i < 150; i++) begin
      rop = 2'($urandom_range(0, 3));
      run_op(rop, W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), lat, bcnt);
      check("rand_latency", 32'(lat), (rop == ALU_MUL) ? 32'(W) : 32'(0));
      if ($urandom_range(0, 3) == 0) tick();
    end

    repeat (3) tick();
    check("queue_empty", 32'(exp_q.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
